cmd_sched: RTL and testbench
============================

// Module: cmd_sched
// PURPOSE
//  Command scheduler between UART_wrapper and cmd_cfg. Buffers incoming cmd/data packets in a FIFO.
//  Replays them to cmd_cfg using the cmd_rdy/clr_cmd_rdy handshake, in arrival order.
//  Urgent commands (EMER_LAND, MTRS_OFF) bypass the queue and flush pending entries.
//  Watchdogs cmd_cfg for a missing clr_cmd_rdy.
// PARAMETERS
//  DEPTH      4          FIFO entries; power of 2, >=2
//  TO_CYCLES  1_000_000  cycles in PRESENT without clr_cmd_rdy before stall_err sets
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  in_rdy       in   1   UART_wrapper packet valid; held until in_clr
//  in_cmd       in   8   UART_wrapper opcode
//  in_data      in   16  UART_wrapper payload
//  in_clr       out  1   combinational accept strobe back to UART_wrapper
//  cmd_rdy      out  1   packet valid to cmd_cfg
//  cmd          out  8   opcode to cmd_cfg (registered)
//  data         out  16  payload to cmd_cfg (registered)
//  clr_cmd_rdy  in   1   cmd_cfg consumed packet
//  count        out  $clog2(DEPTH)+1  FIFO occupancy (excludes urgent slot and output reg)
//  flushed      out  1   one-cycle pulse when an urgent cmd dropped >=1 queued entry
//  stall_err    out  1   sticky; set on watchdog expiry, cleared only by reset
// BEHAVIOUR
//  Reset: cmd_rdy=0, cmd=8'h00, data=16'h0000, count=0, flushed=0, stall_err=0.
//   FIFO pointers, urgent slot and watchdog are all cleared; state=IDLE.
//  Urgent opcodes: 8'h07 EMER_LAND, 8'h08 MTRS_OFF. All other opcodes are normal.
//  Accept: in_clr = in_rdy & (urgent(in_cmd) | count<DEPTH). Capture occurs on the same clk edge.
//   Full uses the registered count; a pop in the same cycle does not free space.
//   When full, a normal packet is back-pressured (in_clr=0) and no data is lost.
//  Normal accept: pushes {in_cmd,in_data} at wr_ptr; pointers wrap mod DEPTH.
//  Urgent accept:
//   - writes the urgent slot; a newer urgent overwrites an unissued older one;
//   - clears the FIFO (count<=0, rd_ptr<=wr_ptr);
//   - pulses flushed if count was nonzero.
//   The packet held in cmd/data (already PRESENT) is never retracted.
//  FSM IDLE/PRESENT:
//   IDLE: if urgent slot valid -> load it (urgent has priority); else if count>0 -> pop head.
//    On either load -> PRESENT with cmd_rdy=1 on the next cycle.
//    Latency: packet accepted into an empty block at edge N gives cmd_rdy=1 after edge N+1.
//   PRESENT: cmd/data held stable and cmd_rdy=1 until clr_cmd_rdy is sampled high.
//    Then -> IDLE with cmd_rdy=0 for at least one cycle before the next packet.
//  Watchdog: counter runs only in PRESENT and clears on leaving PRESENT.
//   At TO_CYCLES it sets stall_err and saturates. The FSM keeps presenting; no auto-drop.
//  Simultaneous events:
//   - urgent accept in the same cycle as IDLE pop: the urgent slot is written and the FIFO is cleared;
//     the normal head popped that cycle is still issued, and the urgent packet follows it.
//   - normal push + pop in the same cycle: count unchanged.
//  clr_cmd_rdy while IDLE: ignored.
//  Reset mid-PRESENT: cmd_rdy drops asynchronously and all queued and urgent entries are lost.
// STRUCTURE
//  Shared package quad_pkg:
//   - opcode localparams REQ_BATT=01, SET_PTCH=02, SET_ROLL=03, SET_YAW=04, SET_THRST=05,
//     CALIBRATE=06, EMER_LAND=07, MTRS_OFF=08;
//   - typedef cmd_pkt_t {logic [7:0] cmd; logic [15:0] data;};
//   - function is_urgent().
//  Sub-module cmd_fifo: DEPTH x cmd_pkt_t, with push/pop/flush/count ports.
//  FSM, urgent slot and watchdog stay in cmd_sched.
// TESTING (DEPTH=4, TO_CYCLES=16 override; cmd_cfg modelled by a bench responder)
//  1 Pass-through: one packet 02/FF0F, responder clears after 3 cycles
//    -> in_clr same cycle; cmd_rdy one cycle later; cmd=02 data=FF0F; count returns to 0.
//  2 Backpressure: responder stalled, 6 normal packets offered
//    -> 1 in output reg, count=4, 6th in_clr=0 until a clr frees space; no packet lost.
//  3 Flush: 01 presented plus 03,04,05 queued; offer 08
//    -> in_clr=1, flushed pulse, count=0; after 01 clears, next presented is 08; 03-05 never appear.
//  4 Wrap/order: stream 10 packets 01..06 repeating, random responder delays
//    -> delivered in order with data intact; pointers wrap twice.
//  5 Watchdog: hold clr_cmd_rdy low 16 cycles in PRESENT
//    -> stall_err=1 and stays 1 after a later clr; cmd stable throughout.
//  6 Reset mid-PRESENT with 2 queued: assert rst_n=0 between edges
//    -> cmd_rdy=0 immediately; after release count=0 and no packet is issued.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared opcodes, command packet type, FSM state type and urgency helper
package quad_pkg;
    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } cmd_pkt_t;

    typedef enum logic {IDLE, PRESENT} sched_state_t;

    function automatic logic is_urgent(input logic [7:0] c);
        return c == EMER_LAND || c == MTRS_OFF;
    endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH-entry packet FIFO with single-cycle flush
//  clk, rst_n   clock, async active-low reset
//  push, wr_pkt write packet at tail (caller guarantees not full)
//  pop          drop head (caller guarantees not empty); rd_pkt shows head
//  flush        discard all entries (never asserted together with push)
//  count        occupancy 0..DEPTH
module cmd_fifo
    import quad_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  cmd_pkt_t      wr_pkt,
    input  logic          pop,
    input  logic          flush,
    output cmd_pkt_t      rd_pkt,
    output logic [CW-1:0] count
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    cmd_pkt_t mem [DEPTH];

    assign rd_pkt = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_pkt;

    // Flush moves the read pointer onto the write pointer so stale entries are unreachable.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= flush ? wr_ptr : rd_ptr + AW'(pop);
            count  <= flush ? '0 : count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: buffers UART packets and replays them to cmd_cfg with urgent bypass and watchdog
//  clk, rst_n                 clock, async active-low reset
//  in_rdy, in_cmd, in_data    packet offered by UART_wrapper; in_clr accepts it (combinational)
//  cmd_rdy, cmd, data         registered packet presented to cmd_cfg; clr_cmd_rdy consumes it
//  count                      queued entries (excludes urgent slot and output register)
//  flushed                    pulse when an urgent packet discarded queued entries
//  stall_err                  sticky watchdog expiry flag
module cmd_sched
    import quad_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TO_CYCLES = 1_000_000,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int WW = $clog2(TO_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_rdy,
    input  logic [7:0]    in_cmd,
    input  logic [15:0]   in_data,
    output logic          in_clr,
    output logic          cmd_rdy,
    output logic [7:0]    cmd,
    output logic [15:0]   data,
    input  logic          clr_cmd_rdy,
    output logic [CW-1:0] count,
    output logic          flushed,
    output logic          stall_err
);
    sched_state_t  state;
    logic          urg_vld;
    cmd_pkt_t      urg_pkt, rd_pkt, nxt_pkt;
    logic [WW-1:0] wd;
    logic          urg, urg_acc, push, pop, load_urg;

    // Full is judged on the registered count, so a same-cycle pop never frees space.
    assign urg      = is_urgent(in_cmd);
    assign in_clr   = in_rdy & (urg | count < CW'(DEPTH));
    assign urg_acc  = in_clr & urg;
    assign push     = in_clr & ~urg;
    assign load_urg = state == IDLE & urg_vld;
    assign pop      = state == IDLE & ~urg_vld & count != '0;
    assign nxt_pkt  = load_urg ? urg_pkt : rd_pkt;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wr_pkt('{cmd: in_cmd, data: in_data}),
        .pop   (pop),
        .flush (urg_acc),
        .rd_pkt(rd_pkt),
        .count (count)
    );

    // A new urgent write wins over clearing the slot, so an urgent arriving while the
    // previous one is being loaded is kept and issued next.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            urg_vld   <= 1'b0;
            urg_pkt   <= '0;
            cmd_rdy   <= 1'b0;
            cmd       <= '0;
            data      <= '0;
            flushed   <= 1'b0;
            stall_err <= 1'b0;
            wd        <= '0;
        end else begin
            flushed <= urg_acc & count != '0;
            if (urg_acc) begin
                urg_vld <= 1'b1;
                urg_pkt <= '{cmd: in_cmd, data: in_data};
            end else if (load_urg) urg_vld <= 1'b0;
            if (state == IDLE) begin
                wd <= '0;
                if (load_urg | pop) begin
                    cmd     <= nxt_pkt.cmd;
                    data    <= nxt_pkt.data;
                    cmd_rdy <= 1'b1;
                    state   <= PRESENT;
                end
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                state   <= IDLE;
                wd      <= '0;
            end else if (wd == WW'(TO_CYCLES - 1)) stall_err <= 1'b1;
            else wd <= wd + WW'(1);
        end
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: randomized scoreboard bench for cmd_sched against a queue-based reference model
module tb_cmd_sched;
    import quad_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk = 0, rst_n = 0, in_rdy = 0, clr_cmd_rdy = 0;
    logic [7:0]  in_cmd = 0;
    logic [15:0] in_data = 0;
    logic        in_clr, cmd_rdy, flushed, stall_err;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [2:0]  count;

    int compared = 0, mismatched = 0, delivered = 0;

    cmd_sched #(.DEPTH(DEPTH), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_rdy(in_rdy), .in_cmd(in_cmd), .in_data(in_data),
        .in_clr(in_clr), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .count(count), .flushed(flushed), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending queue, urgent slot, output-busy flag, watchdog cycle count.
    cmd_pkt_t mq[$], exp_q[$], m_urg, cur;
    bit m_urg_v, m_busy, m_flush, m_stall, saw_flush, prev_rdy;
    int m_wd;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mq.delete(); exp_q.delete();
            m_urg_v = 0; m_busy = 0; m_flush = 0; m_stall = 0; m_wd = 0;
        end else begin
            bit u, acc;
            int pre;
            u   = in_cmd == 8'h07 || in_cmd == 8'h08;
            acc = in_rdy && (u || mq.size() < DEPTH);
            chk("in_clr", in_clr, acc);
            pre = mq.size();
            if (!m_busy) begin
                m_wd = 0;
                if (m_urg_v) begin
                    exp_q.push_back(m_urg); m_urg_v = 0; m_busy = 1;
                end else if (pre > 0) begin
                    exp_q.push_back(mq.pop_front()); m_busy = 1;
                end
            end else if (clr_cmd_rdy) begin
                m_busy = 0; m_wd = 0;
            end else begin
                m_wd++;
                if (m_wd >= TO) m_stall = 1;
            end
            m_flush = 0;
            if (acc && u) begin
                m_flush = pre != 0;
                mq.delete();
                m_urg_v = 1;
                m_urg = '{in_cmd, in_data};
            end else if (acc) mq.push_back('{in_cmd, in_data});
        end

    // Monitor: compares every presented packet with the scoreboard head.
    always @(negedge clk)
        if (!rst_n) prev_rdy = 0;
        else begin
            chk("cmd_rdy", cmd_rdy, m_busy);
            chk("count", count, mq.size());
            chk("flushed", flushed, m_flush);
            chk("stall_err", stall_err, m_stall);
            if (flushed) saw_flush = 1;
            if (cmd_rdy && !prev_rdy) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected: got %0h/%0h expected none", cmd, data);
                end else begin
                    cur = exp_q.pop_front();
                    chk("cmd", cmd, cur.cmd);
                    chk("data", data, cur.data);
                end
            end else if (cmd_rdy) chk("hold", {cmd, data}, cur);
            prev_rdy = cmd_rdy;
        end

    // cmd_cfg responder: clears after a random delay unless held.
    bit hold = 1;
    int dlo = 0, dhi = 0, wc = 0;
    initial forever begin
        @(negedge clk);
        clr_cmd_rdy = 0;
        if (cmd_rdy && !hold) begin
            if (wc <= 0) begin
                clr_cmd_rdy = 1;
                wc = $urandom_range(dhi, dlo);
            end else wc--;
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] c, input logic [15:0] d);
        int n = 0;
        in_rdy = 1; in_cmd = c; in_data = d;
        do begin
            @(posedge clk);
            n++;
        end while (!in_clr && n < 2000);
        if (n >= 2000) begin
            compared++; mismatched++;
            $display("FAIL send_timeout: got no in_clr expected accept of %0h", c);
        end
        @(negedge clk);
        in_rdy = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_data", data, 0);
        chk("rst_count", count, 0);
        chk("rst_flushed", flushed, 0);
        chk("rst_stall", stall_err, 0);
        rst_n = 1;
        @(negedge clk);

        hold = 0; dlo = 3; dhi = 3; wc = 3;
        send(8'h02, 16'hFF0F);
        repeat (10) @(negedge clk);
        chk("t1_count", count, 0);
        chk("t1_delivered", delivered, 1);

        hold = 1;
        fork
            for (int i = 0; i < 6; i++) send(8'(i % 6 + 1), 16'($urandom));
            begin
                repeat (12) @(negedge clk);
                chk("t2_count", count, 4);
                chk("t2_backpressure", in_clr, 0);
                dlo = 0; dhi = 2; wc = 0; hold = 0;
            end
        join
        repeat (40) @(negedge clk);
        chk("t2_delivered", delivered, 7);

        hold = 1; saw_flush = 0;
        send(8'h01, 16'h1111);
        send(8'h03, 16'h3333);
        send(8'h04, 16'h4444);
        send(8'h05, 16'h5555);
        send(8'h08, 16'h8888);
        repeat (3) @(negedge clk);
        chk("t3_saw_flush", saw_flush, 1);
        chk("t3_count", count, 0);
        dlo = 1; dhi = 1; wc = 1; hold = 0;
        repeat (20) @(negedge clk);
        chk("t3_delivered", delivered, 9);

        dlo = 0; dhi = 5;
        for (int i = 0; i < 10; i++) begin
            send(8'(i % 6 + 1), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 30; i++) begin
            send(($urandom_range(0, 7) == 0) ? 8'($urandom_range(7, 8)) : 8'($urandom_range(1, 6)),
                 16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (60) @(negedge clk);

        chk("t5_pre_stall", stall_err, 0);
        hold = 1;
        send(8'h02, 16'h1234);
        repeat (25) @(negedge clk);
        chk("t5_stall", stall_err, 1);
        dlo = 0; dhi = 0; wc = 0; hold = 0;
        repeat (5) @(negedge clk);
        chk("t5_stall_sticky", stall_err, 1);

        hold = 1;
        send(8'h01, 16'hA001);
        send(8'h02, 16'hA002);
        send(8'h03, 16'hA003);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("t6_cmd_rdy_async", cmd_rdy, 0);
        chk("t6_count_async", count, 0);
        @(negedge clk);
        rst_n = 1; hold = 0; wc = 0;
        d = delivered;
        repeat (15) @(negedge clk);
        chk("t6_count", count, 0);
        chk("t6_no_issue", delivered, d);
        chk("t6_stall_cleared", stall_err, 0);
        chk("leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
